// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch/sequencing stage feeding the decoder
module fetch_unit #(
   parameter int                PC_W     = 8,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic             clk,
   input  logic             init,
   input  logic             start,
   output logic [PC_W-1:0]  imem_addr,
   output logic             imem_rd_en,
   input  logic [8:0]       imem_data,
   output logic [8:0]       inst,
   output logic             decoder_en,
   input  logic             branch,
   input  logic             branchi,
   input  logic             jump,
   input  logic [5:0]       immediate,
   input  logic [PC_W-1:0]  branch_target,
   input  logic             exec_done,
   input  logic             done,
   output logic [PC_W-1:0]  pc,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] inst_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_HALT
   } state_t;

   state_t          state, state_nx;
   logic            retire;
   logic [PC_W-1:0] pc_nx;
   logic [PC_W-1:0] off6;
   logic [PC_W-1:0] off4;

   always_ff @(posedge clk or posedge init) begin
      if (init) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      retire     = 1'b0;
      imem_rd_en = 1'b0;
      decoder_en = 1'b0;
      running    = 1'b0;
      halted     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_FETCH;
         end
         S_FETCH: begin
            imem_rd_en = 1'b1;
            running    = 1'b1;
            state_nx   = S_WAIT;
         end
         S_WAIT: begin
            running  = 1'b1;
            state_nx = S_DECODE;
         end
         S_DECODE: begin
            decoder_en = 1'b1;
            running    = 1'b1;
            state_nx   = S_EXEC;
         end
         S_EXEC: begin
            running = 1'b1;
            if (exec_done) begin
               retire   = 1'b1;
               state_nx = done ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Branch offsets are sign-extended to PC width; additions wrap modulo 2^PC_W.
   always_comb begin
      off6 = {{(PC_W-6){immediate[5]}}, immediate};
      off4 = {{(PC_W-4){immediate[3]}}, immediate[3:0]};
      if (branch)                 pc_nx = branch_target;
      else if (branchi && jump)   pc_nx = pc + off6;
      else if (branchi)           pc_nx = pc + off4;
      else                        pc_nx = pc + PC_W'(1);
   end

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         pc         <= RESET_PC;
         inst       <= '0;
         inst_count <= '0;
      end else begin
         if (state == S_WAIT) inst <= imem_data;
         if (retire) begin
            if (inst_count != {CNT_W{1'b1}}) inst_count <= inst_count + CNT_W'(1);
            if (!done) pc <= pc_nx;
         end
      end
   end

   assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
   localparam int PC_W  = 8;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             init, start;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_rd_en;
   logic [8:0]       imem_data;
   logic [8:0]       inst;
   logic             decoder_en;
   logic             branch, branchi, jump;
   logic [5:0]       immediate;
   logic [PC_W-1:0]  branch_target;
   logic             exec_done, done;
   logic [PC_W-1:0]  pc;
   logic             running, halted;
   logic [CNT_W-1:0] inst_count;

   fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
      .clk(clk), .init(init), .start(start),
      .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
      .inst(inst), .decoder_en(decoder_en),
      .branch(branch), .branchi(branchi), .jump(jump), .immediate(immediate),
      .branch_target(branch_target), .exec_done(exec_done), .done(done),
      .pc(pc), .running(running), .halted(halted), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   logic [8:0] mem [256];
   always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

   int n_tests = 0;
   int n_fail  = 0;
   int m_pc    = 0;
   int m_cnt   = 0;

   typedef struct {
      logic       br, bi, jp;
      logic [5:0] imm;
      logic [7:0] tgt;
      logic       dn;
      int         delay;
      logic       glitch;
      int         exp_pc;
   } vec_t;
   vec_t vecs[14];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_next(input int cur, input logic br, input logic bi,
                                   input logic jp, input logic [5:0] imm, input logic [7:0] tgt);
      int off;
      if (br) return int'(tgt);
      if (!bi) return (cur + 1) % (1 << PC_W);
      if (jp) begin
         off = int'(imm);
         if (off >= 32) off -= 64;
      end else begin
         off = int'(imm[3:0]);
         if (off >= 8) off -= 16;
      end
      return (cur + off + (1 << PC_W)) % (1 << PC_W);
   endfunction

   task automatic do_start;
      start = 1'b1;
      step;
      start = 1'b0;
   endtask

   // Entered with the DUT in its FETCH cycle; leaves it one cycle after retire.
   task automatic run_instr(input logic br, input logic bi, input logic jp,
                            input logic [5:0] imm, input logic [7:0] tgt, input logic dn,
                            input int delay, input logic glitch, input int exp_pc);
      chk("fetch_rd_en", int'(imem_rd_en), 1);
      chk("fetch_addr", int'(imem_addr), m_pc);
      if (glitch) exec_done = 1'b1;
      step;
      chk("wait_no_dec", int'(decoder_en), 0);
      chk("wait_no_rd", int'(imem_rd_en), 0);
      step;
      exec_done = 1'b0;
      chk("decode_en", int'(decoder_en), 1);
      chk("inst", int'(inst), int'(mem[m_pc]));
      branch = br; branchi = bi; jump = jp; immediate = imm; branch_target = tgt; done = dn;
      step;
      chk("exec_dec_low", int'(decoder_en), 0);
      for (int i = 0; i < delay; i++) begin
         chk("exec_hold_pc", int'(pc), m_pc);
         chk("exec_no_fetch", int'(imem_rd_en), 0);
         step;
      end
      exec_done = 1'b1;
      step;
      exec_done = 1'b0;
      branch = 1'b0; branchi = 1'b0; jump = 1'b0; done = 1'b0;
      if (m_cnt < CMAX) m_cnt++;
      if (!dn) m_pc = exp_pc;
      chk("pc", int'(pc), m_pc);
      chk("inst_count", int'(inst_count), m_cnt);
      if (dn) chk("halted", int'(halted), 1);
      else    chk("refetch", int'(imem_rd_en), 1);
   endtask

   initial begin
      init = 1'b1; start = 1'b0; exec_done = 1'b0; done = 1'b0;
      branch = 1'b0; branchi = 1'b0; jump = 1'b0; immediate = '0; branch_target = '0;
      for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
      mem[0] = 9'h1E0;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'h00,      8'h00, 1'b0, 0,  1'b0, 1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 6'h00,      8'h00, 1'b0, 0,  1'b1, 2};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'h00,      8'h05, 1'b0, 0,  1'b0, 5};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 6'b111110,  8'h00, 1'b0, 1,  1'b0, 3};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 6'h00,      8'h05, 1'b0, 0,  1'b0, 5};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'b110011,  8'h00, 1'b0, 0,  1'b0, 8};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 6'h00,      8'h0A, 1'b0, 2,  1'b0, 10};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 6'h01,      8'h40, 1'b0, 0,  1'b0, 'h40};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'h00,      8'hFF, 1'b0, 0,  1'b0, 'hFF};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'h00,      8'h00, 1'b0, 0,  1'b1, 'h00};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 6'h00,      8'h00, 1'b0, 0,  1'b0, 'h01};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 6'b111100,  8'h00, 1'b0, 0,  1'b0, 'hFD};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 6'b001000,  8'h00, 1'b0, 20, 1'b0, 'hF5};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 6'h05,      8'h33, 1'b1, 0,  1'b0, 'hF5};

      step; step;
      chk("rst_pc", int'(pc), 0);
      chk("rst_inst", int'(inst), 0);
      chk("rst_rd_en", int'(imem_rd_en), 0);
      chk("rst_dec_en", int'(decoder_en), 0);
      chk("rst_flags", int'({running, halted}), 0);
      chk("rst_count", int'(inst_count), 0);
      init = 1'b0;
      step;
      chk("idle_no_fetch", int'(imem_rd_en), 0);

      do_start;
      foreach (vecs[k])
         run_instr(vecs[k].br, vecs[k].bi, vecs[k].jp, vecs[k].imm, vecs[k].tgt,
                   vecs[k].dn, vecs[k].delay, vecs[k].glitch, vecs[k].exp_pc);

      chk("halt_running", int'(running), 0);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step;
         chk("halt_no_fetch", int'(imem_rd_en), 0);
         chk("halt_stays", int'(halted), 1);
         chk("halt_pc", int'(pc), 'hF5);
      end
      start = 1'b0;
      init = 1'b1;
      #1;
      chk("halt_init_pc", int'(pc), 0);
      chk("halt_init_flags", int'({running, halted}), 0);
      chk("halt_init_count", int'(inst_count), 0);
      init = 1'b0;
      m_pc = 0; m_cnt = 0;
      step;

      // Reset while a read is outstanding in WAIT.
      do_start;
      run_instr(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 0, 1'b0, 1);
      step;
      init = 1'b1;
      #1;
      chk("wrst_pc", int'(pc), 0);
      chk("wrst_inst", int'(inst), 0);
      chk("wrst_outputs", int'({imem_rd_en, decoder_en, running, halted}), 0);
      chk("wrst_count", int'(inst_count), 0);
      init = 1'b0;
      m_pc = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("wrst_no_dec", int'(decoder_en), 0);
         chk("wrst_idle", int'({imem_rd_en, running}), 0);
      end

      do_start;
      for (int n = 0; n < 120; n++) begin
         logic       br, bi, jp;
         logic [5:0] imm;
         logic [7:0] tgt;
         br  = ($urandom_range(0, 3) == 0);
         bi  = ($urandom_range(0, 1) == 0);
         jp  = 1'($urandom);
         imm = 6'($urandom);
         tgt = 8'($urandom);
         run_instr(br, bi, jp, imm, tgt, 1'b0, $urandom_range(0, 2), 1'($urandom),
                   ref_next(m_pc, br, bi, jp, imm, tgt));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
